i2c_poll_scheduler: RTL and testbench
=====================================

// Module: i2c_poll_scheduler
// PURPOSE
//  Master-board sequencer for the 3-slave I2C board: every poll period reads the Switch slave (0x57), then writes the
//  byte read to the LED slave (0x55) and the FND slave (0x56). Drives a transaction-level I2C master core via valid/ready/done.
//  Handles NACK retry and error counting; exposes last switch value and status.
// PARAMETERS
//  POLL_PERIOD    100_000  clk cycles between poll-cycle starts (1 ms @ 100 MHz); >=2
//  MAX_RETRY      3        re-attempts per transaction after NACK (0..15)
//  TIMEOUT_CYCLES 200_000  per-transaction watchdog limit (used only with I2C_SCHED_TIMEOUT_EN)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  async active-high reset
//  enable     in   1  periodic polling enable
//  trig       in   1  1-cycle pulse: start a poll cycle now (if IDLE)
//  txn_valid  out  1  transaction request; held until txn_ready
//  txn_ready  in   1  master core accepts request
//  txn_addr   out  7  7-bit slave address
//  txn_rw     out  1  1=read, 0=write
//  txn_wdata  out  8  write byte
//  txn_done   in   1  1-cycle pulse: transaction finished
//  txn_nack   in   1  valid with txn_done: address/data NACK
//  txn_rdata  in   8  valid with txn_done on reads
//  txn_abort  out  1  1-cycle pulse: watchdog abort to master core
//  sw_value   out  8  last successfully read switch byte
//  err_count  out  8  saturating count of transactions given up
//  cycle_done out  1  1-cycle pulse at end of every poll cycle
//  busy       out  1  high whenever state != IDLE
//  state_dbg  out  4  current state encoding (LED debug)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, period counter 0, retry count 0.
//  States: IDLE(0) RD_SW_REQ(1) RD_SW_WAIT(2) WR_LED_REQ(3) WR_LED_WAIT(4) WR_FND_REQ(5) WR_FND_WAIT(6) DONE(7).
//  Period counter: increments in IDLE while enable=1; clears when enable=0 or on cycle start.
//   Start when counter==POLL_PERIOD-1 or trig=1 -> RD_SW_REQ next cycle. trig outside IDLE is ignored.
//  *_REQ: txn_valid=1 with addr/rw/wdata stable; on txn_valid&txn_ready -> *_WAIT, txn_valid low next cycle.
//  *_WAIT: txn_done ignored in any other state; on txn_done:
//   nack=0: RD captures txn_rdata into sw_value -> WR_LED_REQ; WR_LED -> WR_FND_REQ; WR_FND -> DONE.
//   nack=1, retries<MAX_RETRY: retries++, back to same *_REQ.
//   nack=1, retries==MAX_RETRY: err_count++ (sat at 255).
//    RD failure -> DONE (both writes skipped, sw_value kept). WR failure -> next step as if success.
//  Retry count clears on entry to every new *_REQ step (not on retry).
//  LED and FND writes send sw_value (post-capture).
//  DONE: cycle_done=1 for one cycle -> IDLE.
//  enable falling mid-cycle: current cycle completes; no new periodic start.
//  rst mid-transaction: txn_valid drops immediately (async). Master core is reset by the same rst.
//  Simultaneous txn_done and txn_ready: impossible by protocol; only the one meaningful in current state is honoured.
// CONFIGURATION
//  I2C_SCHED_TIMEOUT_EN defined:
//   cycle counter runs in *_WAIT. Reaching TIMEOUT_CYCLES -> txn_abort pulse.
//   The step is then treated as a NACK (retry/give-up rules above).
//  Undefined: *_WAIT waits indefinitely; txn_abort tied 0; TIMEOUT_CYCLES unused.
// STRUCTURE
//  i2c_sched_pkg: state_t enum (4-bit, values above); LED_ADDR=7'h55, FND_ADDR=7'h56, SW_ADDR=7'h57; RW_READ=1'b1, RW_WRITE=1'b0.
//  Sub-module i2c_sched_timer: loadable/clearable up-counter with terminal flag.
//   Instanced for the period counter and, under the macro, the watchdog.
// TESTING
//  1 enable=1, POLL_PERIOD=20, slave model returns 0xA5 -> read 0x57 at cycle 20, then writes 0x55<-A5, 0x56<-A5;
//    sw_value=A5; cycle_done once.
//  2 trig pulse with enable=0 -> one full cycle starts next clk; no further cycles.
//  3 0x57 NACKs 2x then ACKs 0x3C (MAX_RETRY=3) -> 3 read requests; writes carry 0x3C; err_count=0.
//  4 0x55 always NACKs -> 4 LED attempts, err_count=1, FND write 0x56 still issued, cycle_done pulses.
//  5 txn_ready held low 10 cycles -> txn_valid/addr/rw/wdata stable throughout; rst asserted in RD_SW_WAIT
//    -> all outputs 0 immediately, IDLE.
//  6 (macro on, TIMEOUT_CYCLES=50) txn_done never arrives -> txn_abort at 50 cycles, 4 attempts, err_count=1, DONE reached.

Source files
------------

// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the I2C poll scheduler: state encoding, slave addresses, R/W codes.
package i2c_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_RD_SW_REQ   = 4'd1,
    ST_RD_SW_WAIT  = 4'd2,
    ST_WR_LED_REQ  = 4'd3,
    ST_WR_LED_WAIT = 4'd4,
    ST_WR_FND_REQ  = 4'd5,
    ST_WR_FND_WAIT = 4'd6,
    ST_DONE        = 4'd7
  } state_t;

  localparam logic [6:0] LED_ADDR = 7'h55;
  localparam logic [6:0] FND_ADDR = 7'h56;
  localparam logic [6:0] SW_ADDR  = 7'h57;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_sched_timer.sv
// Loadable/clearable up-counter that stops at LIMIT-1 and flags it as terminal.
module i2c_sched_timer #(
  parameter int unsigned LIMIT = 2,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_term
);

  logic [CNT_W-1:0] r_count;

  assign o_term = (r_count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && !o_term) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Poll sequencer: read switch slave, then write the byte to LED and FND slaves, with NACK retry.
// Optional per-transaction watchdog enabled by defining I2C_SCHED_TIMEOUT_EN.
module i2c_poll_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int unsigned POLL_PERIOD    = 100_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trig,
  output logic       txn_valid,
  input  logic       txn_ready,
  output logic [6:0] txn_addr,
  output logic       txn_rw,
  output logic [7:0] txn_wdata,
  input  logic       txn_done,
  input  logic       txn_nack,
  input  logic [7:0] txn_rdata,
  output logic       txn_abort,
  output logic [7:0] sw_value,
  output logic [7:0] err_count,
  output logic       cycle_done,
  output logic       busy,
  output logic [3:0] state_dbg
);

  state_t      r_state;
  logic        r_valid;
  logic [6:0]  r_addr;
  logic        r_rw;
  logic [7:0]  r_wdata;
  logic [3:0]  r_retry;
  logic [7:0]  r_sw;
  logic [7:0]  r_err;
  logic        r_cycle_done;
  logic        r_abort;

  logic        w_idle;
  logic        w_start;
  logic        w_period_term;
  logic        w_timeout;
  logic        w_resolve;
  logic        w_fail;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_start = w_idle && (trig || (enable && w_period_term));

  i2c_sched_timer #(.LIMIT(POLL_PERIOD)) u_period (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (!enable || w_start),
    .i_en       (w_idle && enable),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_term     (w_period_term)
  );

`ifdef I2C_SCHED_TIMEOUT_EN
  logic w_wait;
  assign w_wait = (r_state == ST_RD_SW_WAIT) || (r_state == ST_WR_LED_WAIT) ||
                  (r_state == ST_WR_FND_WAIT);

  i2c_sched_timer #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (!w_wait),
    .i_en       (w_wait),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_term     (w_timeout)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  // A watchdog expiry resolves the step exactly like a NACK; a real done always wins.
  assign w_resolve = txn_done || w_timeout;
  assign w_fail    = !txn_done || txn_nack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_wdata      <= '0;
      r_retry      <= '0;
      r_sw         <= '0;
      r_err        <= '0;
      r_cycle_done <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_cycle_done <= 1'b0;
      r_abort      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RD_SW_REQ;
            r_valid <= 1'b1;
            r_addr  <= SW_ADDR;
            r_rw    <= RW_READ;
            r_wdata <= '0;
            r_retry <= '0;
          end
        end
        // Each *_WAIT encoding is its *_REQ encoding plus one.
        ST_RD_SW_REQ, ST_WR_LED_REQ, ST_WR_FND_REQ: begin
          if (txn_ready) begin
            r_valid <= 1'b0;
            r_state <= state_t'(r_state + 4'd1);
          end
        end
        ST_RD_SW_WAIT, ST_WR_LED_WAIT, ST_WR_FND_WAIT: begin
          if (w_resolve) begin
            r_abort <= !txn_done;
            if (w_fail && (r_retry < 4'(MAX_RETRY))) begin
              r_retry <= r_retry + 4'd1;
              r_valid <= 1'b1;
              r_state <= state_t'(r_state - 4'd1);
            end else begin
              if (w_fail) r_err <= sat_inc8(r_err);
              case (r_state)
                ST_RD_SW_WAIT: begin
                  if (w_fail) begin
                    r_state      <= ST_DONE;
                    r_cycle_done <= 1'b1;
                  end else begin
                    r_sw    <= txn_rdata;
                    r_state <= ST_WR_LED_REQ;
                    r_valid <= 1'b1;
                    r_addr  <= LED_ADDR;
                    r_rw    <= RW_WRITE;
                    r_wdata <= txn_rdata;
                    r_retry <= '0;
                  end
                end
                ST_WR_LED_WAIT: begin
                  r_state <= ST_WR_FND_REQ;
                  r_valid <= 1'b1;
                  r_addr  <= FND_ADDR;
                  r_rw    <= RW_WRITE;
                  r_wdata <= r_sw;
                  r_retry <= '0;
                end
                default: begin
                  r_state      <= ST_DONE;
                  r_cycle_done <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign txn_valid  = r_valid;
  assign txn_addr   = r_addr;
  assign txn_rw     = r_rw;
  assign txn_wdata  = r_wdata;
  assign txn_abort  = r_abort;
  assign sw_value   = r_sw;
  assign err_count  = r_err;
  assign cycle_done = r_cycle_done;
  assign busy       = !w_idle;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Directed bench for i2c_poll_scheduler with a behavioural master-core responder and transaction scoreboard.
module tb_i2c_poll_scheduler;

  logic       clk = 1'b0;
  logic       rst, enable, trig;
  logic       txn_valid, txn_ready, txn_rw, txn_done, txn_nack, txn_abort;
  logic [6:0] txn_addr;
  logic [7:0] txn_wdata, txn_rdata, sw_value, err_count;
  logic       cycle_done, busy;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  i2c_poll_scheduler #(.POLL_PERIOD(20), .MAX_RETRY(3), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_addr(txn_addr), .txn_rw(txn_rw),
    .txn_wdata(txn_wdata), .txn_done(txn_done), .txn_nack(txn_nack), .txn_rdata(txn_rdata),
    .txn_abort(txn_abort), .sw_value(sw_value), .err_count(err_count),
    .cycle_done(cycle_done), .busy(busy), .state_dbg(state_dbg)
  );

  typedef struct packed {logic [6:0] addr; logic rw; logic [7:0] wdata; logic chk_wd;} exp_t;
  typedef struct packed {logic nack; logic nodone; logic [7:0] rdata;} rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  exp_t m_e;
  rsp_t m_r, pend_rsp;
  int   n_chk = 0, n_err = 0;
  int   cd_cnt = 0, ab_cnt = 0, pend = 0;
  bit   hold_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [6:0] a, input logic rw, input logic [7:0] wd);
    exp_t e;
    e.addr = a; e.rw = rw; e.wdata = wd; e.chk_wd = !rw;
    exp_q.push_back(e);
  endtask

  task automatic push_rsp(input logic nack, input logic nodone, input logic [7:0] rd);
    rsp_t r;
    r.nack = nack; r.nodone = nodone; r.rdata = rd;
    rsp_q.push_back(r);
  endtask

  task automatic wait_cd(input int target, input string tag);
    int n = 0;
    while (cd_cnt < target && n < 2000) begin @(negedge clk); n++; end
    chk(tag, cd_cnt >= target, 1);
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (state_dbg != s && n < 500) begin @(negedge clk); n++; end
    chk(tag, state_dbg, s);
  endtask

  always @(negedge clk) begin
    if (cycle_done) cd_cnt++;
    if (txn_abort) ab_cnt++;
  end

  // Master-core model: accepts requests, checks them against the scoreboard, answers after 3 cycles.
  initial begin
    txn_ready = 1'b0; txn_done = 1'b0; txn_nack = 1'b0; txn_rdata = 8'h00;
    forever begin
      @(negedge clk);
      txn_ready = 1'b0; txn_done = 1'b0; txn_nack = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          txn_done = 1'b1; txn_nack = pend_rsp.nack; txn_rdata = pend_rsp.rdata;
        end
      end else if (txn_valid && !hold_ready) begin
        txn_ready = 1'b1;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          chk("sb_addr", txn_addr, m_e.addr);
          chk("sb_rw", txn_rw, m_e.rw);
          if (m_e.chk_wd) chk("sb_wdata", txn_wdata, m_e.wdata);
        end
        if (rsp_q.size() != 0) m_r = rsp_q.pop_front();
        else begin m_r.nack = 1'b0; m_r.nodone = 1'b0; m_r.rdata = 8'h00; end
        if (!m_r.nodone) begin pend = 3; pend_rsp = m_r; end
      end
    end
  end

  initial begin
    int n, c0;
    logic [16:0] snap;
    rst = 1'b1; enable = 1'b0; trig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", txn_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_sw", sw_value, 0);
    chk("rst_err", err_count, 0);
    chk("rst_cd", cycle_done, 0);
    chk("rst_abort", txn_abort, 0);
    rst = 1'b0;

    // periodic poll: first request after exactly POLL_PERIOD clocks
    push_rsp(1'b0, 1'b0, 8'hA5);
    push_exp(7'h57, 1'b1, 8'h00); push_exp(7'h55, 1'b0, 8'hA5); push_exp(7'h56, 1'b0, 8'hA5);
    @(negedge clk);
    c0 = cd_cnt; enable = 1'b1; n = 0;
    while (!txn_valid && n < 100) begin @(negedge clk); n++; end
    chk("t1_latency", n, 20);
    chk("t1_addr", txn_addr, 7'h57);
    wait_cd(c0 + 1, "t1_cycle_done");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1_cd_once", cd_cnt - c0, 1);
    chk("t1_sw", sw_value, 8'hA5);
    chk("t1_err", err_count, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // trig with enable low: one cycle starting next clock, nothing afterwards
    push_rsp(1'b0, 1'b0, 8'h5A);
    push_exp(7'h57, 1'b1, 8'h00); push_exp(7'h55, 1'b0, 8'h5A); push_exp(7'h56, 1'b0, 8'h5A);
    c0 = cd_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    chk("t2_start", {txn_valid, state_dbg}, {1'b1, 4'd1});
    wait_cd(c0 + 1, "t2_cycle_done");
    repeat (60) @(negedge clk);
    chk("t2_no_more", cd_cnt - c0, 1);
    chk("t2_idle", busy, 0);
    chk("t2_sw", sw_value, 8'h5A);
    chk("t2_sb_empty", exp_q.size(), 0);

    // read NACKed twice then acked
    push_rsp(1'b1, 1'b0, 8'h00); push_rsp(1'b1, 1'b0, 8'h00); push_rsp(1'b0, 1'b0, 8'h3C);
    repeat (3) push_exp(7'h57, 1'b1, 8'h00);
    push_exp(7'h55, 1'b0, 8'h3C); push_exp(7'h56, 1'b0, 8'h3C);
    c0 = cd_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_cd(c0 + 1, "t3_cycle_done");
    repeat (3) @(negedge clk);
    chk("t3_sw", sw_value, 8'h3C);
    chk("t3_err", err_count, 0);
    chk("t3_sb_empty", exp_q.size(), 0);

    // LED always NACKs: 4 attempts, give up, FND still written
    push_rsp(1'b0, 1'b0, 8'h81);
    repeat (4) push_rsp(1'b1, 1'b0, 8'h00);
    push_exp(7'h57, 1'b1, 8'h00);
    repeat (4) push_exp(7'h55, 1'b0, 8'h81);
    push_exp(7'h56, 1'b0, 8'h81);
    c0 = cd_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_cd(c0 + 1, "t4_cycle_done");
    repeat (3) @(negedge clk);
    chk("t4_err", err_count, 1);
    chk("t4_sw", sw_value, 8'h81);
    chk("t4_sb_empty", exp_q.size(), 0);

    // read always NACKs: writes skipped, sw_value kept
    repeat (4) push_rsp(1'b1, 1'b0, 8'hEE);
    repeat (4) push_exp(7'h57, 1'b1, 8'h00);
    c0 = cd_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_cd(c0 + 1, "t4b_cycle_done");
    repeat (10) @(negedge clk);
    chk("t4b_err", err_count, 2);
    chk("t4b_sw", sw_value, 8'h81);
    chk("t4b_sb_empty", exp_q.size(), 0);
    chk("t4b_cd_once", cd_cnt - c0, 1);

    // stalled ready: request held stable; then reset while waiting
    hold_ready = 1'b1;
    push_exp(7'h57, 1'b1, 8'h00);
    push_rsp(1'b0, 1'b1, 8'h00);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    snap = {txn_valid, txn_addr, txn_rw, txn_wdata};
    chk("t5_valid", txn_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_stable", {txn_valid, txn_addr, txn_rw, txn_wdata}, snap);
    end
    hold_ready = 1'b0;
    wait_state(4'd2, "t5_in_wait");
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", txn_valid, 0);
    chk("t5_rst_state", state_dbg, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_sw", sw_value, 0);
    chk("t5_rst_err", err_count, 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_q.delete();
    @(negedge clk);

`ifdef I2C_SCHED_TIMEOUT_EN
    // done never arrives: watchdog aborts each of 4 attempts
    repeat (4) push_rsp(1'b0, 1'b1, 8'h00);
    repeat (4) push_exp(7'h57, 1'b1, 8'h00);
    c0 = cd_cnt;
    n = ab_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_state(4'd2, "t6_in_wait");
    begin
      int k = 0;
      while (!txn_abort && k < 200) begin @(negedge clk); k++; end
      chk("t6_abort_latency", k, 50);
    end
    wait_cd(c0 + 1, "t6_cycle_done");
    repeat (3) @(negedge clk);
    chk("t6_aborts", ab_cnt - n, 4);
    chk("t6_err", err_count, 1);
    chk("t6_sb_empty", exp_q.size(), 0);
`else
    chk("no_abort", ab_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
